// File: rtl/powerup_controller_pkg.sv
// ----------------------------------------------------------------------------
// powerup_controller_pkg
//   Shared definitions for the powerup controller and its per-powerup timers:
//   timer FSM state encoding, seconds-counter width and the lane index of each
//   powerup inside the packed per-lane vectors used by the top level.
// ----------------------------------------------------------------------------
package powerup_controller_pkg;

    // Width of every seconds counter and secs_left output.
    localparam int SECS_W    = 4;

    // One lane per powerup. The lane numbering matches sw_override bit
    // positions: [1] invincible, [0] speedy.
    localparam int NUM_LANES = 2;
    localparam int LANE_INV  = 1;
    localparam int LANE_SPD  = 0;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACTIVE   = 2'd1,
        ST_COOLDOWN = 2'd2
    } timer_state_e;

    typedef logic [SECS_W-1:0] secs_t;

endpackage

// File: rtl/powerup_timer.sv
// ----------------------------------------------------------------------------
// powerup_timer
//   One powerup's lifecycle: IDLE -> ACTIVE (DUR seconds) -> COOLDOWN (COOL
//   seconds) -> IDLE, advanced by the shared 1 s tick.
//
//   Ports
//     clock_100mhz  in   system clock
//     reset_n       in   synchronous active-low reset
//     game_active   in   low forces IDLE and drops pickups
//     tick          in   one-cycle 1 s strobe from the shared prescaler
//     pickup        in   pickup strobe (each high cycle counts)
//     active        out  next-state view: FSM will be ACTIVE after this edge
//     secs_left     out  next-state view: counter if going ACTIVE, else 0
//
//   active/secs_left expose the next-state values so the single output
//   register in the top gives pickup-to-output latency of exactly one edge.
// ----------------------------------------------------------------------------
module powerup_timer
    import powerup_controller_pkg::*;
#(
    parameter int DUR  = 5,
    parameter int COOL = 3
) (
    input  logic  clock_100mhz,
    input  logic  reset_n,
    input  logic  game_active,
    input  logic  tick,
    input  logic  pickup,
    output logic  active,
    output secs_t secs_left
);

    localparam secs_t DUR_S  = SECS_W'(DUR);
    localparam secs_t COOL_S = SECS_W'(COOL);
    localparam secs_t ONE_S  = SECS_W'(1);

    timer_state_e state_q, state_d;
    secs_t        secs_q,  secs_d;

    always_ff @(posedge clock_100mhz) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            secs_q  <= '0;
        end else begin
            state_q <= state_d;
            secs_q  <= secs_d;
        end
    end

    always_comb begin
        state_d = state_q;
        secs_d  = secs_q;
        if (!game_active) begin
            // Abort: nothing owed, no cooldown.
            state_d = ST_IDLE;
            secs_d  = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (pickup) begin
                        state_d = ST_ACTIVE;
                        secs_d  = DUR_S;
                    end
                end
                ST_ACTIVE: begin
                    // A refresh beats a same-cycle tick; no stacking.
                    if (pickup) begin
                        secs_d = DUR_S;
                    end else if (tick) begin
                        if (secs_q > ONE_S) begin
                            secs_d = secs_q - ONE_S;
                        end else begin
                            state_d = ST_COOLDOWN;
                            secs_d  = COOL_S;
                        end
                    end
                end
                ST_COOLDOWN: begin
                    // Pickups are dropped here, not queued.
                    if (tick) begin
                        if (secs_q > ONE_S) begin
                            secs_d = secs_q - ONE_S;
                        end else begin
                            state_d = ST_IDLE;
                            secs_d  = '0;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    secs_d  = '0;
                end
            endcase
        end
    end

    assign active    = (state_d == ST_ACTIVE);
    assign secs_left = active ? secs_d : '0;

endmodule

// File: rtl/powerup_controller.sv
// ----------------------------------------------------------------------------
// powerup_controller
//   Times and sequences the invincible and speedy powerups. A shared
//   prescaler makes a 1 s tick; one powerup_timer per powerup runs the
//   ACTIVE/COOLDOWN sequence; a single register stage merges the debug
//   override and drives the player-facing outputs.
//
//   Ports
//     clock_100mhz          in   system clock
//     reset_n               in   synchronous active-low reset
//     game_active           in   low aborts all powerups, holds prescaler
//     pickup_invincible     in   invincible collectible taken
//     pickup_speedy         in   speedy collectible taken
//     sw_override[1:0]      in   debug force: [1] invincible, [0] speedy
//     player_is_invincible  out  registered invincible-in-effect
//     player_is_speedy      out  registered speedy-in-effect
//     invincible_secs_left  out  remaining ACTIVE seconds, else 0
//     speedy_secs_left      out  remaining ACTIVE seconds, else 0
//     powerup_expiring      out  some powerup ACTIVE with 1 s left
// ----------------------------------------------------------------------------
module powerup_controller
    import powerup_controller_pkg::*;
#(
    parameter int TICK_DIV    = 100_000_000,
    parameter int INVINC_SECS = 5,
    parameter int SPEEDY_SECS = 8,
    parameter int COOL_SECS   = 3
) (
    input  logic              clock_100mhz,
    input  logic              reset_n,
    input  logic              game_active,
    input  logic              pickup_invincible,
    input  logic              pickup_speedy,
    input  logic [1:0]        sw_override,
    output logic              player_is_invincible,
    output logic              player_is_speedy,
    output logic [SECS_W-1:0] invincible_secs_left,
    output logic [SECS_W-1:0] speedy_secs_left,
    output logic              powerup_expiring
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    // ------------------------------------------------------------------
    // 1 s prescaler. Held at 0 while the game is stopped so the first tick
    // after re-entry lands a full TICK_DIV cycles later.
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] presc_q;
    logic             tick;

    always_ff @(posedge clock_100mhz) begin
        if (!reset_n || !game_active) begin
            presc_q <= '0;
        end else if (presc_q == CNT_LAST) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + 1'b1;
        end
    end

    assign tick = game_active && (presc_q == CNT_LAST);

    // ------------------------------------------------------------------
    // Per-powerup timers
    // ------------------------------------------------------------------
    logic [NUM_LANES-1:0]             pickup_vec;
    logic [NUM_LANES-1:0]             active_nxt;
    logic [NUM_LANES-1:0][SECS_W-1:0] secs_nxt;

    always_comb begin
        pickup_vec           = '0;
        pickup_vec[LANE_INV] = pickup_invincible;
        pickup_vec[LANE_SPD] = pickup_speedy;
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        powerup_timer #(
            .DUR  ((i == LANE_INV) ? INVINC_SECS : SPEEDY_SECS),
            .COOL (COOL_SECS)
        ) u_timer (
            .clock_100mhz (clock_100mhz),
            .reset_n      (reset_n),
            .game_active  (game_active),
            .tick         (tick),
            .pickup       (pickup_vec[i]),
            .active       (active_nxt[i]),
            .secs_left    (secs_nxt[i])
        );
    end

    // ------------------------------------------------------------------
    // Output register. The override only touches the effect flags, never
    // the timers or the seconds outputs, and is itself gated by game_active.
    // ------------------------------------------------------------------
    logic [NUM_LANES-1:0]             force_vec;
    logic [NUM_LANES-1:0]             active_q;
    logic [NUM_LANES-1:0][SECS_W-1:0] secs_q;

    assign force_vec = sw_override & {NUM_LANES{game_active}};

    always_ff @(posedge clock_100mhz) begin
        if (!reset_n) begin
            active_q <= '0;
            secs_q   <= '0;
        end else begin
            active_q <= active_nxt | force_vec;
            secs_q   <= secs_nxt;
        end
    end

    // secs_q is nonzero only while ACTIVE, so "==1" alone identifies the
    // last active second.
    always_comb begin
        powerup_expiring = 1'b0;
        for (int i = 0; i < NUM_LANES; i++) begin
            powerup_expiring = powerup_expiring | (secs_q[i] == SECS_W'(1));
        end
    end

    assign player_is_invincible = active_q[LANE_INV];
    assign player_is_speedy     = active_q[LANE_SPD];
    assign invincible_secs_left = secs_q[LANE_INV];
    assign speedy_secs_left     = secs_q[LANE_SPD];

endmodule

// File: tb/tb_powerup_controller.sv
// ----------------------------------------------------------------------------
// tb_powerup_controller
//   Directed bench for powerup_controller with TICK_DIV=10, INVINC_SECS=5,
//   SPEEDY_SECS=8, COOL_SECS=3. Inputs change 1 time unit after a rising
//   edge; outputs are checked at the same point, i.e. they reflect the edge
//   just taken. With game_active raised before edge E+1, ticks are sampled
//   at edges E+10, E+20, ...
// ----------------------------------------------------------------------------
module tb_powerup_controller;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       game_active;
    logic       pinv;
    logic       pspd;
    logic [1:0] sw;
    logic       o_inv;
    logic       o_spd;
    logic [3:0] o_isecs;
    logic [3:0] o_ssecs;
    logic       o_exp;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    powerup_controller #(
        .TICK_DIV    (10),
        .INVINC_SECS (5),
        .SPEEDY_SECS (8),
        .COOL_SECS   (3)
    ) dut (
        .clock_100mhz         (clk),
        .reset_n              (reset_n),
        .game_active          (game_active),
        .pickup_invincible    (pinv),
        .pickup_speedy        (pspd),
        .sw_override          (sw),
        .player_is_invincible (o_inv),
        .player_is_speedy     (o_spd),
        .invincible_secs_left (o_isecs),
        .speedy_secs_left     (o_ssecs),
        .powerup_expiring     (o_exp)
    );

    // {inv, spd, isecs, ssecs, expiring}
    function automatic logic [10:0] pk(input logic i, input logic s,
                                       input logic [3:0] a, input logic [3:0] b,
                                       input logic e);
        return {i, s, a, b, e};
    endfunction

    typedef struct {
        logic        ga;
        logic        pi;
        logic        ps;
        logic [1:0]  sw;
        int          ncyc;
        logic [10:0] expv;
    } vec_t;

    function automatic vec_t mk(input logic ga, input logic pi, input logic ps,
                                input logic [1:0] s, input int n,
                                input logic [10:0] e);
        vec_t v;
        v.ga = ga; v.pi = pi; v.ps = ps; v.sw = s; v.ncyc = n; v.expv = e;
        return v;
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string nm, input logic [10:0] expv);
        logic [10:0] got;
        got = {o_inv, o_spd, o_isecs, o_ssecs, o_exp};
        checks++;
        if (got !== expv) begin
            failures++;
            $display("FAIL %s: got inv=%0b spd=%0b isecs=%0d ssecs=%0d exp=%0b, want inv=%0b spd=%0b isecs=%0d ssecs=%0d exp=%0b",
                     nm, got[10], got[9], got[8:5], got[4:1], got[0],
                     expv[10], expv[9], expv[8:5], expv[4:1], expv[0]);
        end
    endtask

    // Holds reset for 3 edges with the game stopped and checks the reset
    // state; leaves reset released but no edge taken yet.
    task automatic do_reset(input string nm);
        reset_n = 1'b0; game_active = 1'b0; pinv = 1'b0; pspd = 1'b0; sw = 2'b00;
        step(3);
        check(nm, pk(0, 0, 0, 0, 0));
        reset_n = 1'b1;
    endtask

    vec_t tbl[20];

    initial begin
        // Scenario 1-3 as one continuous timeline, E = last edge before ga rises.
        tbl[0]  = mk(1, 0, 0, 2'b00,  1, pk(0, 0, 0, 0, 0));  // E+1  idle
        tbl[1]  = mk(1, 1, 0, 2'b00,  1, pk(1, 0, 5, 0, 0));  // E+2  pickup
        tbl[2]  = mk(1, 0, 0, 2'b00,  8, pk(1, 0, 4, 0, 0));  // E+10 tick 1
        tbl[3]  = mk(1, 0, 0, 2'b00, 30, pk(1, 0, 1, 0, 1));  // E+40 tick 4
        tbl[4]  = mk(1, 0, 0, 2'b00,  9, pk(1, 0, 1, 0, 1));  // E+49 still 1
        tbl[5]  = mk(1, 0, 0, 2'b00,  1, pk(0, 0, 0, 0, 0));  // E+50 expire
        tbl[6]  = mk(1, 1, 0, 2'b00,  1, pk(0, 0, 0, 0, 0));  // E+51 cooldown drop
        tbl[7]  = mk(1, 0, 0, 2'b00, 28, pk(0, 0, 0, 0, 0));  // E+79
        tbl[8]  = mk(1, 1, 0, 2'b00,  1, pk(0, 0, 0, 0, 0));  // E+80 last cooldown tick
        tbl[9]  = mk(1, 1, 0, 2'b00,  1, pk(1, 0, 5, 0, 0));  // E+81 accepted
        tbl[10] = mk(1, 0, 0, 2'b00, 29, pk(1, 0, 2, 0, 0));  // E+110
        tbl[11] = mk(1, 0, 0, 2'b00,  9, pk(1, 0, 2, 0, 0));  // E+119
        tbl[12] = mk(1, 1, 0, 2'b00,  1, pk(1, 0, 5, 0, 0));  // E+120 refresh vs tick
        tbl[13] = mk(1, 0, 0, 2'b00, 10, pk(1, 0, 4, 0, 0));  // E+130
        tbl[14] = mk(1, 0, 0, 2'b00, 70, pk(0, 0, 0, 0, 0));  // E+200 idle again
        tbl[15] = mk(1, 1, 1, 2'b00,  1, pk(1, 1, 5, 8, 0));  // E+201 both
        tbl[16] = mk(1, 0, 0, 2'b00, 39, pk(1, 1, 1, 4, 1));  // E+240
        tbl[17] = mk(1, 0, 0, 2'b00, 10, pk(0, 1, 0, 3, 0));  // E+250 inv expires
        tbl[18] = mk(1, 0, 0, 2'b00, 20, pk(0, 1, 0, 1, 1));  // E+270
        tbl[19] = mk(1, 0, 0, 2'b00, 10, pk(0, 0, 0, 0, 0));  // E+280 spd expires

        do_reset("reset_init");
        for (int k = 0; k < 20; k++) begin
            game_active = tbl[k].ga; pinv = tbl[k].pi; pspd = tbl[k].ps; sw = tbl[k].sw;
            step(1);
            pinv = 1'b0; pspd = 1'b0;
            step(tbl[k].ncyc - 1);
            check($sformatf("tbl[%0d]", k), tbl[k].expv);
        end

        // game_active dropped mid-ACTIVE, then re-entry with a fresh pickup.
        do_reset("reset_abort");
        game_active = 1'b1; pinv = 1'b1;
        step(1); pinv = 1'b0;
        check("abort_start", pk(1, 0, 5, 0, 0));
        step(19);
        check("abort_secs3", pk(1, 0, 3, 0, 0));
        step(5);
        game_active = 1'b0;
        step(1);
        check("abort_drop", pk(0, 0, 0, 0, 0));
        pinv = 1'b1;
        step(1); pinv = 1'b0;
        check("abort_pickup_ignored", pk(0, 0, 0, 0, 0));
        game_active = 1'b1; pinv = 1'b1;
        step(1); pinv = 1'b0;
        check("reentry_pickup", pk(1, 0, 5, 0, 0));
        step(8);
        check("reentry_no_early_tick", pk(1, 0, 5, 0, 0));
        step(1);
        check("reentry_first_tick", pk(1, 0, 4, 0, 0));

        // Debug override.
        do_reset("reset_override");
        game_active = 1'b1; sw = 2'b11;
        step(1);
        check("override_both", pk(1, 1, 0, 0, 0));
        sw = 2'b10;
        step(1);
        check("override_inv_only", pk(1, 0, 0, 0, 0));
        sw = 2'b11; game_active = 1'b0;
        step(1);
        check("override_gated", pk(0, 0, 0, 0, 0));
        sw = 2'b00;

        // Reset mid-COOLDOWN, then an immediate pickup.
        do_reset("reset_cool_pre");
        game_active = 1'b1; pinv = 1'b1;
        step(1); pinv = 1'b0;
        step(49);
        check("cool_entered", pk(0, 0, 0, 0, 0));
        step(5);
        reset_n = 1'b0;
        step(1);
        check("cool_reset", pk(0, 0, 0, 0, 0));
        reset_n = 1'b1; pinv = 1'b1;
        step(1); pinv = 1'b0;
        check("post_reset_pickup", pk(1, 0, 5, 0, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
